// File: rtl/multi_timer_pkg.sv
// Shared types and constants for the multi-channel cycle timer.
// Optional feature macro: MULTI_TIMER_REMAINING_EN (adds the "remaining" output).
package multi_timer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WORKING = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : multi_timer_pkg

// File: rtl/timer_channel.sv
// One independent timer channel: two-state FSM, up-counter, registered done/expired.
// Optional feature macro: MULTI_TIMER_REMAINING_EN (registered cycles-remaining output).
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] cycles,
`ifdef MULTI_TIMER_REMAINING_EN
  output logic [WIDTH-1:0] remaining,
`endif
  output logic             done,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cycles_q, cycles_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             terminal;
  logic             start_ok;

  assign terminal = (state_q == WORKING) && (count_q == cycles_q);
  assign start_ok = (cycles != '0);

  // Next-state logic: stop beats go, go beats normal counting; a restart on the
  // terminal cycle still reports the period that just completed.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cycles_d  = cycles_q;
    mode_d    = mode_q;
    done_d    = done_q;
    expired_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (go && start_ok) begin
      state_d   = WORKING;
      cycles_d  = cycles;
      mode_d    = periodic ? MODE_PERIODIC : MODE_ONESHOT;
      count_d   = ONE;
      done_d    = 1'b0;
      expired_d = terminal;
    end else if (go && (state_q == WORKING)) begin
      // Restart with a zero period acts as an abort.
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (state_q == WORKING) begin
      if (terminal) begin
        expired_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          count_d = ONE;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      cycles_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      done_q    <= 1'b1;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cycles_q  <= cycles_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign done    = done_q;
  assign expired = expired_q;

`ifdef MULTI_TIMER_REMAINING_EN
  logic [WIDTH-1:0] remaining_q, remaining_d;

  // Remaining count derived from next-state values so it is registered alongside count.
  always_comb begin
    remaining_d = '0;
    if (state_d == WORKING) begin
      remaining_d = cycles_d - count_d + ONE;
    end
  end

  // Remaining-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining = remaining_q;
`endif

endmodule : timer_channel

// File: rtl/multi_timer.sv
// NUM_TIMERS independent cycle timers sharing one clock and reset.
// Optional feature macro: MULTI_TIMER_REMAINING_EN (adds the "remaining" output port).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_TIMERS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TIMERS-1:0]       go,
  input  logic [NUM_TIMERS-1:0]       stop,
  input  logic [NUM_TIMERS-1:0]       periodic,
  input  logic [NUM_TIMERS*WIDTH-1:0] cycles,
`ifdef MULTI_TIMER_REMAINING_EN
  output logic [NUM_TIMERS*WIDTH-1:0] remaining,
`endif
  output logic [NUM_TIMERS-1:0]       done,
  output logic [NUM_TIMERS-1:0]       expired
);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .go       (go[i]),
      .stop     (stop[i]),
      .periodic (periodic[i]),
      .cycles   (cycles[i*WIDTH +: WIDTH]),
`ifdef MULTI_TIMER_REMAINING_EN
      .remaining(remaining[i*WIDTH +: WIDTH]),
`endif
      .done     (done[i]),
      .expired  (expired[i])
    );
  end

endmodule : multi_timer

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (4x32-bit instance plus 1x8-bit instance).
module tb_multi_timer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   go = '0, stop = '0, periodic = '0;
  logic [127:0] cycles = '0;
  logic [3:0]   done, expired;
`ifdef MULTI_TIMER_REMAINING_EN
  logic [127:0] remaining;
  logic [7:0]   rem8;
`endif

  logic [0:0] go8 = '0, stop8 = '0, per8 = '0, done8, exp8;
  logic [7:0] cyc8 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_timer #(.WIDTH(32), .NUM_TIMERS(4)) dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .periodic(periodic), .cycles(cycles),
`ifdef MULTI_TIMER_REMAINING_EN
    .remaining(remaining),
`endif
    .done(done), .expired(expired)
  );

  multi_timer #(.WIDTH(8), .NUM_TIMERS(1)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .stop(stop8), .periodic(per8), .cycles(cyc8),
`ifdef MULTI_TIMER_REMAINING_EN
    .remaining(rem8),
`endif
    .done(done8), .expired(exp8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cyc(input int ch, input logic [31:0] val);
    cycles[ch*32 +: 32] = val;
  endtask

  task automatic idle_all;
    stop = 4'hF; tick; stop = '0; tick;
  endtask

  task automatic test_reset;
    tick; tick;
    rst = 1'b0;
    n_tests++;
    if (done !== 4'hF || expired !== 4'h0) begin
      n_fail++; $display("FAIL reset_state: done=%b expired=%b expected 1111/0000", done, expired);
    end
    for (int i = 0; i < 4; i++) set_cyc(i, 20);
    go = 4'hF; tick; go = '0;
    tick; tick; tick;
    n_tests++;
    if (done !== 4'h0) begin
      n_fail++; $display("FAIL reset_running: done=%b expected 0000", done);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (done !== 4'hF || expired !== 4'h0 || done8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_async: done=%b expired=%b done8=%b expected 1111/0000/1", done, expired, done8);
    end
    tick; rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_tests++;
      if (done !== 4'hF || expired !== 4'h0) begin
        n_fail++; $display("FAIL reset_quiet k=%0d: done=%b expired=%b expected 1111/0000", k, done, expired);
      end
    end
  endtask

  task automatic test_oneshot;
    logic [3:0] ed, ee;
    idle_all;
    set_cyc(0, 5);
    go = 4'b0001; tick; go = '0;
    n_tests++;
    if (done !== 4'b1110 || expired !== 4'h0) begin
      n_fail++; $display("FAIL oneshot_start: done=%b expired=%b expected 1110/0000", done, expired);
    end
    for (int k = 1; k <= 6; k++) begin
      tick;
      ed = (k >= 5) ? 4'hF : 4'b1110;
      ee = (k == 5) ? 4'b0001 : 4'h0;
      n_tests++;
      if (done !== ed || expired !== ee) begin
        n_fail++; $display("FAIL oneshot k=%0d: done=%b expired=%b expected %b/%b", k, done, expired, ed, ee);
      end
    end
  endtask

  task automatic test_periodic_stop;
    logic [3:0]  ed, ee;
    logic [31:0] er;
    idle_all;
    set_cyc(1, 3);
    periodic = 4'b0010; go = 4'b0010; tick; go = '0; periodic = '0;
    n_tests++;
    if (done !== 4'b1101 || expired !== 4'h0) begin
      n_fail++; $display("FAIL periodic_start: done=%b expired=%b expected 1101/0000", done, expired);
    end
`ifdef MULTI_TIMER_REMAINING_EN
    n_tests++;
    if (remaining[63:32] !== 32'd3) begin
      n_fail++; $display("FAIL remaining_start: got %0d expected 3", remaining[63:32]);
    end
`endif
    for (int k = 1; k <= 13; k++) begin
      stop = (k == 10) ? 4'b0010 : 4'h0;
      tick;
      stop = '0;
      ed = (k >= 10) ? 4'hF : 4'b1101;
      ee = (k == 3 || k == 6 || k == 9) ? 4'b0010 : 4'h0;
      n_tests++;
      if (done !== ed || expired !== ee) begin
        n_fail++; $display("FAIL periodic k=%0d: done=%b expired=%b expected %b/%b", k, done, expired, ed, ee);
      end
`ifdef MULTI_TIMER_REMAINING_EN
      er = (k >= 10) ? 32'd0 : 32'(3 - (k % 3));
      n_tests++;
      if (remaining[63:32] !== er) begin
        n_fail++; $display("FAIL remaining k=%0d: got %0d expected %0d", k, remaining[63:32], er);
      end
`endif
    end
  endtask

  task automatic test_restart;
    logic [3:0] ed, ee;
    idle_all;
    set_cyc(2, 10);
    go = 4'b0100; tick; go = '0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) begin set_cyc(2, 2); go = 4'b0100; end
      tick;
      go = '0;
      ed = (k >= 6) ? 4'hF : 4'b1011;
      ee = (k == 6) ? 4'b0100 : 4'h0;
      n_tests++;
      if (done !== ed || expired !== ee) begin
        n_fail++; $display("FAIL restart k=%0d: done=%b expired=%b expected %b/%b", k, done, expired, ed, ee);
      end
    end
  endtask

  task automatic test_edges;
    logic [3:0] ed, ee;
    // go on the terminal cycle: completed period still reported, done stays low
    idle_all;
    set_cyc(0, 3);
    go = 4'b0001; tick; go = '0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) go = 4'b0001;
      tick;
      go = '0;
      ed = (k >= 6) ? 4'hF : 4'b1110;
      ee = (k == 3 || k == 6) ? 4'b0001 : 4'h0;
      n_tests++;
      if (done !== ed || expired !== ee) begin
        n_fail++; $display("FAIL term_restart k=%0d: done=%b expired=%b expected %b/%b", k, done, expired, ed, ee);
      end
    end
    // restart with a zero period aborts
    set_cyc(0, 5);
    go = 4'b0001; tick; go = '0; tick; tick;
    set_cyc(0, 0);
    go = 4'b0001; tick; go = '0;
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (done !== 4'hF || expired !== 4'h0) begin
        n_fail++; $display("FAIL zero_restart k=%0d: done=%b expired=%b expected 1111/0000", k, done, expired);
      end
      tick;
    end
    // zero period from idle ignored
    set_cyc(3, 0);
    go = 4'b1000; tick; go = '0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (done !== 4'hF || expired !== 4'h0) begin
        n_fail++; $display("FAIL zero_idle k=%0d: done=%b expired=%b expected 1111/0000", k, done, expired);
      end
      tick;
    end
    // period of one: done low exactly one cycle
    set_cyc(3, 1);
    go = 4'b1000; tick; go = '0;
    n_tests++;
    if (done !== 4'b0111 || expired !== 4'h0) begin
      n_fail++; $display("FAIL one_start: done=%b expired=%b expected 0111/0000", done, expired);
    end
    tick;
    n_tests++;
    if (done !== 4'hF || expired !== 4'b1000) begin
      n_fail++; $display("FAIL one_end: done=%b expired=%b expected 1111/1000", done, expired);
    end
    tick;
    n_tests++;
    if (done !== 4'hF || expired !== 4'h0) begin
      n_fail++; $display("FAIL one_after: done=%b expired=%b expected 1111/0000", done, expired);
    end
  endtask

  task automatic test_concurrent;
    logic [3:0] ed, ee;
    idle_all;
    for (int i = 0; i < 4; i++) set_cyc(i, 32'(i + 1));
    go = 4'hF; tick; go = '0;
    n_tests++;
    if (done !== 4'h0 || expired !== 4'h0) begin
      n_fail++; $display("FAIL conc_start: done=%b expired=%b expected 0000/0000", done, expired);
    end
    for (int k = 1; k <= 5; k++) begin
      tick;
      for (int i = 0; i < 4; i++) begin
        ed[i] = (k >= i + 1);
        ee[i] = (k == i + 1);
      end
      n_tests++;
      if (done !== ed || expired !== ee) begin
        n_fail++; $display("FAIL conc k=%0d: done=%b expired=%b expected %b/%b", k, done, expired, ed, ee);
      end
    end
  endtask

  task automatic test_stop_go;
    idle_all;
    set_cyc(0, 4);
    go = 4'b0001; stop = 4'b0001; tick; go = '0; stop = '0;
    n_tests++;
    if (done !== 4'hF || expired !== 4'h0) begin
      n_fail++; $display("FAIL stopgo_idle: done=%b expired=%b expected 1111/0000", done, expired);
    end
    set_cyc(1, 8);
    go = 4'b0010; tick; go = '0; tick; tick;
    go = 4'b0010; stop = 4'b0010; tick; go = '0; stop = '0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (done !== 4'hF || expired !== 4'h0) begin
        n_fail++; $display("FAIL stopgo_run k=%0d: done=%b expired=%b expected 1111/0000", k, done, expired);
      end
      tick;
    end
  endtask

  task automatic test_wide;
    cyc8 = 8'd255;
    go8 = 1'b1; tick; go8 = 1'b0;
    n_tests++;
    if (done8 !== 1'b0 || exp8 !== 1'b0) begin
      n_fail++; $display("FAIL wide_start: done=%b expired=%b expected 0/0", done8, exp8);
    end
    for (int k = 1; k <= 257; k++) begin
      tick;
      n_tests++;
      if (done8 !== 1'(k >= 255) || exp8 !== 1'(k == 255)) begin
        n_fail++; $display("FAIL wide k=%0d: done=%b expired=%b expected %b/%b", k, done8, exp8, k >= 255, k == 255);
      end
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic_stop;
    test_restart;
    test_edges;
    test_concurrent;
    test_stop_go;
    test_wide;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multi_timer

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised, multi-channel successor to the single-shot cycle timer.
- NUM_TIMERS independent channels. Each counts a programmable number of cycles after go, in one-shot or periodic mode.
- Each channel supports stop (abort) and restart while running, and produces registered done and expired outputs.
- Used by control FSMs that need several concurrent timeouts/heartbeats without instantiating separate timers.

Parameters:
- WIDTH, 32, bit width of each channel's cycles value and internal counter.
- NUM_TIMERS, 4, number of independent channels (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; one clock domain only.
- go  input  NUM_TIMERS  per-channel start/restart request, sampled on rising edge.
- stop  input  NUM_TIMERS  per-channel abort request.
- periodic  input  NUM_TIMERS  per-channel mode captured with go: 0=one-shot, 1=auto-reload.
- cycles  input  NUM_TIMERS*WIDTH  per-channel period; channel i uses bits [i*WIDTH +: WIDTH].
- done  output  NUM_TIMERS  level: 1 when channel idle/finished, 0 while running.
- expired  output  NUM_TIMERS  one-cycle pulse each time a channel's period completes.

Behaviour:
- Channels are fully independent; no shared arithmetic or arbitration.
- Each channel's FSM has two states, IDLE and WORKING. Its registers are state, count (WIDTH), cycles_r (WIDTH), mode_r, done, expired.
- Reset (async, any time, including mid-count):
  - state=IDLE, count=0, cycles_r=0, mode_r=0.
  - done=1 on every channel; expired=0.
- IDLE, go=1, cycles!=0 at edge T0:
  - Capture cycles into cycles_r and periodic into mode_r; count<=1; state<=WORKING; done<=0.
- IDLE, go=1, cycles==0: request ignored. State unchanged, done stays 1, no expired.
- WORKING, count!=cycles_r: count<=count+1.
- WORKING, count==cycles_r (terminal), one-shot: state<=IDLE; done<=1; expired<=1 for one cycle.
- WORKING, terminal, periodic: count<=1; stay WORKING; done stays 0; expired<=1 for one cycle.
- Latency (one-shot, cycles=N, go sampled at edge T0):
  - done is 0 during exactly N cycles, T0+1..T0+N.
  - done rises and expired pulses after edge T0+N.
- Periodic: expired pulses after edges T0+N, T0+2N, ...
- go while WORKING (restart): reload cycles_r, mode_r and count<=1 as from IDLE; no expired for the aborted period.
  - Restart with cycles==0 behaves as stop.
- go on the terminal cycle: restart wins; expired still pulses for the completed period; done stays 0.
- stop=1 (either state): state<=IDLE; done<=1; expired<=0; count held.
- stop and go in the same cycle: stop wins.
- expired is never asserted on a stop-induced return to IDLE.
- Counter never exceeds cycles_r, so no wrap-around. cycles=2^WIDTH-1 is legal.
- Outputs are registered only; no combinational path from inputs to done/expired.

Optional Feature:
- Macro: MULTI_TIMER_REMAINING_EN.
- Defined: adds output port "remaining", NUM_TIMERS*WIDTH bits, registered, channel i at [i*WIDTH +: WIDTH].
  - Reset value 0.
  - Equals cycles_r-count+1 while WORKING (N right after go, 1 on the terminal cycle; reloads to N in periodic mode).
  - Equals 0 while IDLE.
- Undefined: port and its logic absent; all other behaviour identical.

Decomposition:
- Package multi_timer_pkg: state enum typedef (IDLE, WORKING) and mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
- Sub-module timer_channel (WIDTH parameter) implements one channel's FSM and counter.
- multi_timer is a generate loop of NUM_TIMERS timer_channel instances plus port slicing.

Test Plan:
- Reset: assert rst mid-count on all channels -> immediately done=4'b1111, expired=0; after release, no activity without go.
- One-shot: channel 0, cycles=5, go pulse at T0 -> done[0]=0 for 5 cycles, done[0]=1 and expired[0]=1 for one cycle after edge T0+5; other channels untouched.
- Periodic, stop, and optional feature: channel 1, cycles=3, periodic=1, go; stop at T0+10 ->
  - expired[1] pulses after T0+3, +6, +9; done[1]=1 after T0+10; no further pulses.
  - With MULTI_TIMER_REMAINING_EN: remaining reads 3,2,1,3,2,1...
- Restart and edge cases:
  - Channel 2, cycles=10, go; at T0+4 go with cycles=2 -> expired[2] after T0+6 only.
  - cycles=0 go -> ignored.
  - cycles=1 -> done low exactly one cycle.
- Concurrency and wide counts:
  - All 4 channels started same edge with cycles 1,2,3,4 -> staggered expired pulses, no crosstalk.
  - stop+go same cycle -> channel idle.
  - WIDTH=8, cycles=255 -> done after exactly 255 cycles.
